// File: rtl/crc_pkg.sv
// Shared types and defaults for the serial CRC controller and its LFSR step.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         DEF_MSG_W    = 10;
    localparam int         DEF_CRC_W    = 3;
    localparam logic [2:0] DEF_POLY     = 3'b011;
    localparam logic [2:0] DEF_CRC_INIT = 3'b000;

    // Wide enough to count every bit of a full codeword.
    function automatic int cntWidth(input int msgW, input int crcW);
        return $clog2(msgW + crcW + 1);
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit update of a non-augmented serial CRC LFSR (MSB-first).
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int               CRC_W = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY  = DEF_POLY
) (
    input  logic [CRC_W-1:0] lfsr_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] lfsr_o
);

    logic fb;

    assign fb     = bit_i ^ lfsr_i[CRC_W-1];
    assign lfsr_o = {lfsr_i[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});

endmodule

// File: rtl/crc_serial_ctrl.sv
// Serial CRC sequencer: accepts a word, shifts it MSB-first through the LFSR, presents {msg, crc}.
// Define CRC_CHECK_EN to add the codeword check mode (chk_mode, cw_in, crc_err).
module crc_serial_ctrl
    import crc_pkg::*;
#(
    parameter int               MSG_W    = DEF_MSG_W,
    parameter int               CRC_W    = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY     = DEF_POLY,
    parameter logic [CRC_W-1:0] CRC_INIT = DEF_CRC_INIT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MSG_W-1:0]       data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CRC_W-1:0]       crc_out,
    output logic [MSG_W+CRC_W-1:0] data_out,
`ifdef CRC_CHECK_EN
    input  logic                   chk_mode,
    input  logic [MSG_W+CRC_W-1:0] cw_in,
    output logic                   crc_err,
`endif
    output logic                   busy
);

`ifdef CRC_CHECK_EN
    localparam int SH_W = MSG_W + CRC_W;
`else
    localparam int SH_W = MSG_W;
`endif
    localparam int CNT_W = cntWidth(MSG_W, CRC_W);

    state_t                 state_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;
    logic [CRC_W-1:0]       crc_q;
    logic [MSG_W+CRC_W-1:0] data_out_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CRC_W-1:0]       lfsr_q;
    logic [CRC_W-1:0]       lfsr_d;
    logic [SH_W-1:0]        shreg_q;
    logic [SH_W-1:0]        msg_q;

    logic [SH_W-1:0]        loadWord;
    logic [CNT_W-1:0]       lastCnt;
    logic [MSG_W+CRC_W-1:0] resultWord;

`ifdef CRC_CHECK_EN
    logic chk_q;
    logic crc_err_q;

    // Generate mode pads the message so both modes share one shift register.
    assign loadWord   = chk_mode ? cw_in : {data_in, {CRC_W{1'b0}}};
    assign lastCnt    = chk_q ? CNT_W'(MSG_W + CRC_W - 1) : CNT_W'(MSG_W - 1);
    assign resultWord = chk_q ? msg_q : {msg_q[SH_W-1 -: MSG_W], lfsr_d};
    assign crc_err    = crc_err_q;
`else
    assign loadWord   = data_in;
    assign lastCnt    = CNT_W'(MSG_W - 1);
    assign resultWord = {msg_q, lfsr_d};
`endif

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .lfsr_i (lfsr_q),
        .bit_i  (shreg_q[SH_W-1]),
        .lfsr_o (lfsr_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            crc_q       <= '0;
            data_out_q  <= '0;
            cnt_q       <= '0;
            lfsr_q      <= CRC_INIT;
            shreg_q     <= '0;
            msg_q       <= '0;
`ifdef CRC_CHECK_EN
            chk_q       <= 1'b0;
            crc_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        shreg_q    <= loadWord;
                        msg_q      <= loadWord;
                        lfsr_q     <= CRC_INIT;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
`ifdef CRC_CHECK_EN
                        chk_q      <= chk_mode;
`endif
                    end
                end
                SHIFT: begin
                    lfsr_q  <= lfsr_d;
                    shreg_q <= {shreg_q[SH_W-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                    // The final bit's LFSR update is captured directly as the result.
                    if (cnt_q == lastCnt) begin
                        crc_q       <= lfsr_d;
                        data_out_q  <= resultWord;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef CRC_CHECK_EN
                        crc_err_q   <= chk_q && (lfsr_d != '0);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign crc_out   = crc_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_crc_serial_ctrl.sv
// Directed bench for crc_serial_ctrl with hand-computed CRCs for x^3+x+1.
// Define CRC_CHECK_EN to also exercise the codeword check mode.
module tb_crc_serial_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  data_in;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  crc_out;
    logic [12:0] data_out;
    logic        busy;
`ifdef CRC_CHECK_EN
    logic        chk_mode;
    logic [12:0] cw_in;
    logic        crc_err;
`endif

    int checkCount = 0;
    int passCount  = 0;

    crc_serial_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .crc_out   (crc_out),
        .data_out  (data_out),
`ifdef CRC_CHECK_EN
        .chk_mode  (chk_mode),
        .cw_in     (cw_in),
        .crc_err   (crc_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    // Presents a word in IDLE and returns just after the accepting edge.
    task automatic applyStimulus(input logic [9:0] msg);
        @(negedge clk);
        data_in  = msg;
        in_valid = 1'b1;
        checkOutput("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("busy_after_accept", {63'd0, busy}, 64'd1);
        checkOutput("in_ready_in_shift", {63'd0, in_ready}, 64'd0);
    endtask

    // Counts edges until out_valid is seen, with a bounded budget.
    task automatic waitResult(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!out_valid && edges < 40);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
        checkOutput("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic runWord(input logic [9:0] msg, input logic [2:0] expCrc, input int expLat);
        int edges;
        applyStimulus(msg);
        waitResult(edges);
        checkOutput("latency", 64'(edges), 64'(expLat));
        checkOutput("crc_out", {61'd0, crc_out}, {61'd0, expCrc});
        checkOutput("data_out", {51'd0, data_out}, {51'd0, msg, expCrc});
        handshake();
    endtask

    logic [9:0] b2bWords [3] = '{10'b1100000011, 10'b1011001011, 10'b0000000001};
    logic [2:0] b2bCrcs  [3] = '{3'b100, 3'b000, 3'b011};

    initial begin
        int edges;
        int seen;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
`ifdef CRC_CHECK_EN
        chk_mode  = 1'b0;
        cw_in     = '0;
`endif

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_crc", {61'd0, crc_out}, 64'd0);
        checkOutput("rst_data", {51'd0, data_out}, 64'd0);
        reset = 1'b1;

        // Basic words, including an all-zero message
        runWord(10'b1100000011, 3'b100, 10);
        runWord(10'b1011001011, 3'b000, 10);
        runWord(10'b0000000000, 3'b000, 10);

        // Consumer stalls in DONE while a new word is already offered
        applyStimulus(10'b1011001011);
        waitResult(edges);
        checkOutput("stall_latency", 64'(edges), 64'd10);
        data_in  = 10'b0000000001;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall_out_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("stall_data", {51'd0, data_out}, {51'd0, 13'b1011001011000});
        end
        handshake();
        checkOutput("no_same_cycle_accept", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("accept_after_hs", {63'd0, busy}, 64'd1);
        waitResult(edges);
        checkOutput("post_stall_latency", 64'(edges), 64'd10);
        checkOutput("post_stall_crc", {61'd0, crc_out}, 64'd3);
        checkOutput("post_stall_data", {51'd0, data_out}, {51'd0, 13'b0000000001011});
        handshake();

        // Reset in the 4th SHIFT cycle discards the word
        applyStimulus(10'b1100000011);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_crc", {61'd0, crc_out}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("abort_no_result", 64'(seen), 64'd0);

        // Back-to-back words with in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = b2bWords[k];
            @(posedge clk);
            #1;
            checkOutput("b2b_accept", {63'd0, busy}, 64'd1);
            waitResult(edges);
            checkOutput("b2b_latency", 64'(edges), 64'd10);
            checkOutput("b2b_crc", {61'd0, crc_out}, {61'd0, b2bCrcs[k]});
            @(posedge clk);
            #1;
            checkOutput("b2b_single_result", {63'd0, out_valid}, 64'd0);
            checkOutput("b2b_in_ready", {63'd0, in_ready}, 64'd1);
            if (k == 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;

`ifdef CRC_CHECK_EN
        // Check mode: a valid codeword, then the same word with bit 5 flipped
        chk_mode = 1'b1;
        cw_in    = 13'b1100000011100;
        applyStimulus(10'b0);
        waitResult(edges);
        checkOutput("chk_latency", 64'(edges), 64'd13);
        checkOutput("chk_err_clean", {63'd0, crc_err}, 64'd0);
        checkOutput("chk_crc_clean", {61'd0, crc_out}, 64'd0);
        checkOutput("chk_data", {51'd0, data_out}, {51'd0, 13'b1100000011100});
        handshake();
        cw_in = 13'b1100000111100;
        applyStimulus(10'b0);
        waitResult(edges);
        checkOutput("chk_err_flip", {63'd0, crc_err}, 64'd1);
        checkOutput("chk_crc_flip", {61'd0, crc_out}, 64'd2);
        handshake();
        chk_mode = 1'b0;
        runWord(10'b1100000011, 3'b100, 10);
        checkOutput("gen_err_zero", {63'd0, crc_err}, 64'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
